// File: rtl/queue_read_arbiter_pkg.sv
// Shared types and default sizing for the queue read arbiter and its picker.
package queue_read_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int NQ_DEF        = 4;
   localparam int WIDTH_DEF     = 32;
   localparam int BURST_LEN_DEF = 8;

endpackage

// File: rtl/queue_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping at NQ.
module rr_pick
   import queue_read_arbiter_pkg::*;
#(
   parameter int NQ = NQ_DEF
) (
   input  logic [NQ-1:0]         req,
   input  logic [$clog2(NQ)-1:0] last,
   output logic                  any,
   output logic [$clog2(NQ)-1:0] idx
);

   localparam int IW = $clog2(NQ);

   always_comb begin
      int j;
      logic [IW-1:0] jj;
      any = |req;
      idx = '0;
      j   = 0;
      jj  = '0;
      // Walk from farthest to nearest so the closest requester after last wins.
      for (int k = NQ; k >= 1; k--) begin
         j = int'(last) + k;
         if (j >= NQ) j = j - NQ;
         jj = j[IW-1:0];
         if (req[jj]) idx = jj;
      end
   end

endmodule

// File: rtl/queue_read_arbiter.sv
// Round-robin burst reader draining NQ FIFOs into one registered valid/ready stream.
// Define QUEUE_READ_ARBITER_BURST_EN to hold a grant for up to BURST_LEN words.
module queue_read_arbiter
   import queue_read_arbiter_pkg::*;
#(
   parameter int NQ        = NQ_DEF,
   parameter int WIDTH     = WIDTH_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NQ-1:0]         q_empty,
   input  logic [NQ*WIDTH-1:0]   q_dout,
   output logic [NQ-1:0]         q_rd_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [$clog2(NQ)-1:0] out_src
);

   localparam int IW = $clog2(NQ);

   state_t        state, state_nxt;
   logic [IW-1:0] g, g_nxt;
   logic [IW-1:0] last, last_nxt;
   logic [IW-1:0] pick_idx;
   logic [NQ-1:0] req;
   logic          pick_any;
   logic          acc;
   logic          pop;
   logic          burst_done;
   logic [WIDTH-1:0] head;

   assign req = ~q_empty;

   rr_pick #(.NQ(NQ)) u_pick (
      .req  (req),
      .last (last),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign acc = ~out_valid | out_ready;
   // rst_n gating keeps the strobe low during reset even though state is combinationally valid.
   assign pop = rst_n && (state == GRANT) && acc && !q_empty[g];

   always_comb begin
      head = '0;
      for (int i = 0; i < NQ; i++) begin
         if (g == IW'(i)) head = q_dout[i*WIDTH +: WIDTH];
      end
   end

`ifdef QUEUE_READ_ARBITER_BURST_EN
   localparam int CW = $clog2(BURST_LEN + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc    = cnt + CW'(1);
   assign burst_done = pop && (cnt_inc == CW'(BURST_LEN));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == IDLE && pick_any) begin
         cnt <= '0;
      end else if (pop) begin
         cnt <= cnt_inc;
      end
   end
`else
   // Grants last one word: the effective burst is min(BURST_LEN, 1).
   localparam int BURST_EFF = (BURST_LEN < 1) ? BURST_LEN : 1;

   assign burst_done = pop && (BURST_EFF == 1);
`endif

   always_comb begin
      state_nxt = state;
      g_nxt     = g;
      last_nxt  = last;
      q_rd_en   = '0;
      if (pop) q_rd_en[g] = 1'b1;
      case (state)
         IDLE: begin
            if (pick_any) begin
               g_nxt     = pick_idx;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (burst_done || (acc && q_empty[g])) begin
               last_nxt  = g;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         g         <= '0;
         last      <= IW'(NQ - 1);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else begin
         state <= state_nxt;
         g     <= g_nxt;
         last  <= last_nxt;
         if (pop) begin
            out_valid <= 1'b1;
            out_data  <= head;
            out_src   <= g;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_queue_read_arbiter.sv
// Directed bench for queue_read_arbiter; follows QUEUE_READ_ARBITER_BURST_EN like the RTL.
module tb_queue_read_arbiter;

   localparam int NQ = 4;
   localparam int WIDTH = 32;
   localparam int BL = 8;
`ifdef QUEUE_READ_ARBITER_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NQ-1:0]     q_empty;
   logic [NQ*WIDTH-1:0] q_dout;
   logic [NQ-1:0]     q_rd_en;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [1:0]        out_src;

   logic [WIDTH-1:0] mem [NQ][64];
   int               head [NQ];
   int               tail [NQ];
   logic             qclr;
   int               cyc = 0;

   int checks = 0;
   int failures = 0;

   logic [WIDTH-1:0] col_data [$];
   logic [1:0]       col_src [$];
   int               col_cyc [$];

   queue_read_arbiter #(.NQ(NQ), .WIDTH(WIDTH), .BURST_LEN(BL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .q_empty   (q_empty),
      .q_dout    (q_dout),
      .q_rd_en   (q_rd_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   always #5 clk = ~clk;

   // Source FIFO model: head advances on the DUT's pop strobe.
   always_comb begin
      q_empty = '0;
      q_dout  = '0;
      for (int i = 0; i < NQ; i++) begin
         q_empty[i] = (head[i] == tail[i]);
         q_dout[i*WIDTH +: WIDTH] = mem[i][head[i] & 63];
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NQ; i++) begin
         if (qclr) head[i] <= 0;
         else if (q_rd_en[i] && head[i] != tail[i]) head[i] <= head[i] + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check_eq("rd_onehot", 64'($countones(q_rd_en) <= 1), 64'd1);
         check_eq("rd_on_empty", 64'(q_rd_en & q_empty), 64'd0);
         if (out_valid && out_ready) begin
            col_data.push_back(out_data);
            col_src.push_back(out_src);
            col_cyc.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int q, input logic [WIDTH-1:0] d);
      mem[q][tail[q] & 63] = d;
      tail[q] = tail[q] + 1;
   endtask

   task automatic clear_col();
      col_data.delete();
      col_src.delete();
      col_cyc.delete();
   endtask

   task automatic wait_words(input int n, input int budget);
      for (int t = 0; t < budget; t++) begin
         if (col_data.size() >= n) break;
         step();
      end
      check_eq("word_count", 64'(col_data.size() >= n), 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      qclr = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < NQ; i++) tail[i] = 0;
      step();
      step();
      check_eq("rst_rd_en", 64'(q_rd_en), 64'd0);
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_data", 64'(out_data), 64'd0);
      check_eq("rst_src", 64'(out_src), 64'd0);
      rst_n = 1'b1;
      qclr = 1'b0;
      clear_col();
   endtask

   initial begin
      int c;
      int n;
      int qcnt [NQ];
      int exp_src;
      int exp_gap;

      rst_n = 1'b0;
      qclr = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < NQ; i++) tail[i] = 0;
      do_reset();

      // Idle with every queue empty.
      out_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         step();
         check_eq("idle_rd_en", 64'(q_rd_en), 64'd0);
         check_eq("idle_valid", 64'(out_valid), 64'd0);
      end

      // Single queue stream from q2, including first-word latency.
      c = cyc;
      push(2, 32'hA0);
      push(2, 32'hA1);
      push(2, 32'hA2);
      wait_words(3, 20);
      if (col_data.size() >= 3) begin
         check_eq("single_latency", 64'(col_cyc[0] - c), 64'd2);
         for (int k = 0; k < 3; k++) begin
            check_eq("single_data", 64'(col_data[k]), 64'(32'hA0 + k));
            check_eq("single_src", 64'(col_src[k]), 64'd2);
            if (k > 0) check_eq("single_gap", 64'(col_cyc[k] - col_cyc[k-1]), BURST ? 64'd1 : 64'd2);
         end
      end
      step();
      step();
      check_eq("single_count", 64'(col_data.size()), 64'd3);

      // Burst limit / round-robin order with all queues loaded.
      do_reset();
      out_ready = 1'b1;
      for (int q = 0; q < NQ; q++) begin
         qcnt[q] = 0;
         for (int k = 0; k < 20; k++) push(q, 32'(q * 256 + k));
      end
      wait_words(24, 100);
      if (col_data.size() >= 24) begin
         for (int k = 0; k < 24; k++) begin
            exp_src = BURST ? (k / BL) % NQ : k % NQ;
            check_eq("burst_src", 64'(col_src[k]), 64'(exp_src));
            check_eq("burst_data", 64'(col_data[k]), 64'(exp_src * 256 + qcnt[exp_src]));
            qcnt[exp_src]++;
            if (k > 0) begin
               exp_gap = BURST ? ((k % BL == 0) ? 2 : 1) : 2;
               check_eq("burst_gap", 64'(col_cyc[k] - col_cyc[k-1]), 64'(exp_gap));
            end
         end
      end

      // Backpressure for 5 cycles mid-stream.
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) push(1, 32'(32'hB0 + k));
      for (int t = 0; t < 30; t++) begin
         step();
         if (col_data.size() >= 3 && out_valid) break;
      end
      n = col_data.size();
      out_ready = 1'b0;
      for (int t = 0; t < 5; t++) begin
         step();
         check_eq("bp_valid", 64'(out_valid), 64'd1);
         check_eq("bp_data", 64'(out_data), 64'(32'hB0 + n));
         check_eq("bp_src", 64'(out_src), 64'd1);
         check_eq("bp_rd_en", 64'(q_rd_en), 64'd0);
      end
      out_ready = 1'b1;
      wait_words(10, 40);
      step();
      step();
      check_eq("bp_count", 64'(col_data.size()), 64'd10);
      for (int k = 0; k < 10 && k < col_data.size(); k++)
         check_eq("bp_order", 64'(col_data[k]), 64'(32'hB0 + k));

      // Wrap-around: after a q3 grant, q0 comes before q2.
      do_reset();
      out_ready = 1'b1;
      push(3, 32'h300);
      wait_words(1, 10);
      if (col_src.size() >= 1) check_eq("wrap_first_src", 64'(col_src[0]), 64'd3);
      for (int t = 0; t < 4; t++) step();
      clear_col();
      push(0, 32'h10);
      push(2, 32'h12);
      wait_words(2, 20);
      if (col_src.size() >= 2) begin
         check_eq("wrap_src0", 64'(col_src[0]), 64'd0);
         check_eq("wrap_data0", 64'(col_data[0]), 64'h10);
         check_eq("wrap_src1", 64'(col_src[1]), 64'd2);
         check_eq("wrap_data1", 64'(col_data[1]), 64'h12);
      end

      // Reset during the q1 burst; first grant afterwards goes to the lowest index.
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) push(1, 32'(32'h400 + k));
      for (int k = 0; k < 5; k++) push(2, 32'(32'h500 + k));
      wait_words(3, 30);
      rst_n = 1'b0;
      out_ready = 1'b0;
      push(0, 32'h600);
      push(0, 32'h601);
      #1;
      check_eq("mid_rst_rd_en", 64'(q_rd_en), 64'd0);
      step();
      check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
      check_eq("mid_rst_data", 64'(out_data), 64'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      clear_col();
      wait_words(1, 10);
      if (col_src.size() >= 1) begin
         check_eq("post_rst_src", 64'(col_src[0]), 64'd0);
         check_eq("post_rst_data", 64'(col_data[0]), 64'h600);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/queue_read_arbiter.md
QUEUE_READ_ARBITER -- requirements
Module: queue_read_arbiter

Interface
REQ-001 SHALL have parameter NQ, default 4: number of source queues (2..8).
REQ-002 SHALL have parameter WIDTH, default 32: data width per queue.
REQ-003 SHALL have parameter BURST_LEN, default 8: maximum words popped per grant (1..64).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port q_empty, input, NQ: per-queue empty flag; 0 means q_dout is valid.
REQ-007 SHALL have port q_dout, input, NQ*WIDTH: per-queue head word; queue i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port q_rd_en, output, NQ: per-queue pop strobe; the next head is valid the following cycle.
REQ-009 SHALL have port out_valid, input/output direction output, 1: out_data holds a word.
REQ-010 SHALL have port out_ready, input, 1: the consumer accepts the word this cycle.
REQ-011 SHALL have port out_data, output, WIDTH: registered data word.
REQ-012 SHALL have port out_src, output, clog2(NQ): index of the queue out_data came from.

Function
REQ-013 SHALL run a two-state FSM.
- IDLE: no grant held.
- GRANT: grant register g is valid, and burst counter cnt counts words popped under g.
REQ-014 In IDLE with any q_empty bit at 0, SHALL load g with the first non-empty queue searched round-robin from last+1 (mod NQ), set cnt=0, and go to GRANT; no pop occurs that cycle.
REQ-015 In IDLE with all queues empty, SHALL stay in IDLE.
REQ-016 The accept condition is acc = ~out_valid | out_ready.
REQ-017 In GRANT, when acc=1 and q_empty[g]=0, SHALL assert q_rd_en[g] and load out_data from q_dout[g], out_src from g, out_valid from 1, and increment cnt.
REQ-018 SHALL assert at most one q_rd_en bit per cycle.
REQ-019 SHALL never assert q_rd_en[i] while q_empty[i]=1.
REQ-020 When out_ready=1 and no pop occurs in a cycle, SHALL clear out_valid.
REQ-021 When out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable.
REQ-022 SHALL release the grant (go to IDLE, set last=g) on either of these conditions:
- a pop makes cnt reach BURST_LEN;
- q_empty[g]=1 while acc=1.
REQ-023 Throughput within a grant SHALL be one word per cycle while out_ready=1 and the queue is non-empty.
REQ-024 Each grant change SHALL cost exactly one bubble cycle.
REQ-025 Latency from q_empty[i] falling, with the FSM idle and the consumer ready, to out_valid=1 SHALL be 2 cycles.
REQ-026 The round-robin pointer SHALL wrap from NQ-1 to 0.
REQ-027 A queue going empty and its refill in the same grant SHALL NOT extend the grant beyond the REQ-022 rules.
REQ-028 Words from one queue SHALL leave in queue order.

Reset
REQ-029 With rst_n=0 at a clock edge, SHALL set:
- state IDLE, g=0, cnt=0;
- last=NQ-1, so queue 0 has first priority;
- out_valid=0, out_data=0, out_src=0.
REQ-030 While rst_n=0, q_rd_en SHALL be 0.
REQ-031 A word held in out_data is discarded by reset mid-burst, and no pop SHALL occur in that cycle.

Configuration
REQ-032 SHALL use the macro QUEUE_READ_ARBITER_BURST_EN.
- Defined: grants last up to BURST_LEN words per REQ-022.
- Undefined: the effective BURST_LEN is 1 (re-arbitrate after every word) and the cnt register is omitted.

Structure
REQ-033 A shared package SHALL hold:
- the FSM state enum (IDLE, GRANT);
- the default constants NQ_DEF=4, WIDTH_DEF=32, BURST_LEN_DEF=8.
REQ-034 The round-robin picker SHALL be one sub-module, rr_pick (inputs req[NQ], last; outputs any, idx), and be purely combinational.
REQ-035 The output register and FSM SHALL reside in queue_read_arbiter.

Verification
REQ-036 Reset then idle: hold all q_empty=1 for 20 cycles -> q_rd_en=0, out_valid=0, state IDLE throughout.
REQ-037 Single queue: queue 2 holds 0xA0..0xA2 and out_ready=1 -> out_data sequence is A0,A1,A2 on consecutive cycles, out_src=2, grant released when q_empty[2]=1.
REQ-038 Burst limit: all 4 queues hold 20 words, BURST_LEN=8, macro defined -> 8 words from q0, bubble, 8 from q1, bubble, 8 from q2; with the macro undefined, order is q0,q1,q2,q3,q0 with a bubble between each.
REQ-039 Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data stable, no q_rd_en, and the stream resumes with no word lost or duplicated.
REQ-040 Wrap-around: last grant was q3 and q0 and q2 are non-empty -> next grant is q0.
REQ-041 Reset mid-burst: rst_n=0 for 1 cycle during the q1 burst -> out_valid=0 the next cycle, and the first grant after reset goes to the lowest non-empty index.
